// File: rtl/cfg_cmd_controller_if.sv
// UART byte path between the config command controller and the UART RX/TX blocks.
// Latency: none, wires only.
// Backpressure: the RX side is a one-cycle strobe; the TX side is a valid/ready pair.
interface cfg_cmd_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // UART side: supplies RX bytes and accepts TX bytes
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  // Controller side
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/cfg_cmd_controller.sv
// E32-style mode-3 config command sequencer: parses C0..C4 frames, updates params, streams responses.
// Latency: tx_valid rises 2 cycles after the last frame byte; new params are visible 1 cycle after EXEC.
// Backpressure: each TX byte is held until tx_ready; RX bytes arriving outside IDLE/RX_BODY are dropped.
// Optional inter-byte timeout is built when CFG_TIMEOUT_EN is defined.
module cfg_cmd_controller #(
  parameter logic [39:0] DEFAULT_PARAMS = 40'h00_00_1A_06_44,
  parameter logic [23:0] VERSION_BYTES  = 24'h32_27_00,
  parameter int unsigned CMD_TIMEOUT    = 1000,
  parameter int unsigned RESET_CYCLES   = 2000
) (
  input  logic               internal_clk,
  input  logic               rst_n,
  input  logic               M0_sync,
  input  logic               M1_sync,
  cfg_cmd_controller_if.slave bus,
  output logic [7:0]         ADDH,
  output logic [7:0]         ADDL,
  output logic [7:0]         SPED,
  output logic [7:0]         CHAN,
  output logic [7:0]         OPTION,
  output logic               param_update,
  output logic               AUX_cfg_ctrl
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RESET_LAST = RW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RX_BODY, EXEC, TX_RESP, RESET_WAIT} state_t;

  state_t          state;
  logic [7:0]      hdr;
  logic [2:0]      cnt;
  logic [39:0]     body;
  logic [39:0]     active;
  logic [39:0]     saved;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_dat_q;
  logic            tx_vld_q;
  logic [RW-1:0]   reset_cnt;

  logic            mode3;
  logic            hdr_valid;
  logic            is_param;
  logic [2:0]      last_cnt;
  logic [2:0]      resp_last;
  logic            timeout;

  assign mode3     = M1_sync & M0_sync;
  assign hdr_valid = (bus.rx_data >= 8'hC0) && (bus.rx_data <= 8'hC4);
  assign is_param  = (hdr == 8'hC0) || (hdr == 8'hC2);
  // Body length minus one: 5 parameter bytes for C0/C2, two header repeats otherwise
  assign last_cnt  = is_param ? 3'd4 : 3'd1;
  assign resp_last = (hdr == 8'hC3) ? 3'd3 : 3'd5;

  assign bus.tx_data  = tx_dat_q;
  assign bus.tx_valid = tx_vld_q;

  assign ADDH   = active[39:32];
  assign ADDL   = active[31:24];
  assign SPED   = active[23:16];
  assign CHAN   = active[15:8];
  assign OPTION = active[7:0];

  // Response byte idx for header h; parameter responses read the given param set
  function automatic logic [7:0] resp_byte(input logic [7:0] h, input logic [2:0] idx,
                                           input logic [39:0] p);
    logic [7:0] b;
    b = 8'h00;
    if (h == 8'hC3) begin
      case (idx)
        3'd0:    b = 8'hC3;
        3'd1:    b = VERSION_BYTES[23:16];
        3'd2:    b = VERSION_BYTES[15:8];
        3'd3:    b = VERSION_BYTES[7:0];
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = (h == 8'hC2) ? 8'hC2 : 8'hC0;
        3'd1:    b = p[39:32];
        3'd2:    b = p[31:24];
        3'd3:    b = p[23:16];
        3'd4:    b = p[15:8];
        3'd5:    b = p[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CMD_TIMEOUT);
  logic [TW-1:0] idle_cnt;

  assign timeout = (idle_cnt == TO_LAST);

  // Idle-gap counter: runs only in RX_BODY and restarts on every received byte
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != RX_BODY) || bus.rx_valid) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  // No timeout in this build; CMD_TIMEOUT is referenced so the parameter list is identical
  assign timeout = 1'b0 & (CMD_TIMEOUT != 0);
`endif

  // Command FSM with registered TX, param_update and AUX outputs
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hdr          <= 8'h00;
      cnt          <= 3'd0;
      body         <= 40'h0;
      active       <= DEFAULT_PARAMS;
      saved        <= DEFAULT_PARAMS;
      tx_idx       <= 3'd0;
      tx_dat_q     <= 8'h00;
      tx_vld_q     <= 1'b0;
      reset_cnt    <= '0;
      param_update <= 1'b0;
      AUX_cfg_ctrl <= 1'b1;
    end else begin
      param_update <= 1'b0;
      // AUX is released only after a full cycle spent in IDLE
      AUX_cfg_ctrl <= 1'b0;
      case (state)
        IDLE: begin
          AUX_cfg_ctrl <= 1'b1;
          if (bus.rx_valid && mode3 && hdr_valid) begin
            hdr          <= bus.rx_data;
            cnt          <= 3'd0;
            state        <= RX_BODY;
            AUX_cfg_ctrl <= 1'b0;
          end
        end
        RX_BODY: begin
          // Leaving mode 3 beats a same-cycle byte; a byte beats a same-cycle timeout
          if (!mode3) begin
            state <= IDLE;
          end else if (bus.rx_valid) begin
            if (!is_param && (bus.rx_data != hdr)) begin
              state <= IDLE;
            end else begin
              body <= {body[31:0], bus.rx_data};
              cnt  <= cnt + 3'd1;
              if (cnt == last_cnt) begin
                state <= EXEC;
              end
            end
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        EXEC: begin
          case (hdr)
            8'hC0: begin
              active       <= body;
              saved        <= body;
              param_update <= 1'b1;
            end
            8'hC2: begin
              active       <= body;
              param_update <= 1'b1;
            end
            8'hC4: begin
              active       <= saved;
              param_update <= 1'b1;
            end
            default: ;
          endcase
          if (hdr == 8'hC4) begin
            reset_cnt <= '0;
            state     <= RESET_WAIT;
          end else begin
            // Byte 0 is the header only, so it does not depend on this cycle's write
            tx_idx   <= 3'd0;
            tx_dat_q <= resp_byte(hdr, 3'd0, active);
            tx_vld_q <= 1'b1;
            state    <= TX_RESP;
          end
        end
        TX_RESP: begin
          if (tx_vld_q && bus.tx_ready) begin
            if (tx_idx == resp_last) begin
              tx_vld_q <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_dat_q <= resp_byte(hdr, tx_idx + 3'd1, active);
            end
          end
        end
        RESET_WAIT: begin
          if (reset_cnt == RESET_LAST) begin
            state <= IDLE;
          end else begin
            reset_cnt <= reset_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
